// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard sequencing controller.
// Build option: PS2_TYPEMATIC_FILTER_EN (auto-repeat filtering, see ps2_kbd_ctrl.sv).
package ps2_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    // Active-low segments {dp, g, f, e, d, c, b, a}; decimal point kept dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Single hex digit to active-low 7-segment pattern (DP off). Purely combinational.
module hex7seg
    import ps2_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code sequencer: prefix FSM, held-key tracking, press counter, 4-digit display.
// Build option: define PS2_TYPEMATIC_FILTER_EN to stop auto-repeat makes from being counted.
module ps2_kbd_ctrl
    import ps2_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             make_pulse,
    output logic             break_pulse,
    output logic             proto_err,
    output logic [7:0]       seg_code_lo,
    output logic [7:0]       seg_code_hi,
    output logic [7:0]       seg_cnt_lo,
    output logic [7:0]       seg_cnt_hi
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic               in_ready_reg;
    logic               key_down_reg, key_down_next;
    logic [7:0]         code_reg, code_next;
    logic               ext_reg, ext_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               make_reg, make_next;
    logic               break_reg, break_next;
    logic               err_reg, err_next;

    logic               accept;
    logic               do_make, do_break, ev_ext, held_match, count_make;

    assign accept = in_valid && in_ready_reg;

    always_comb begin
        state_next    = state_reg;
        to_cnt_next   = to_cnt_reg;
        key_down_next = key_down_reg;
        code_next     = code_reg;
        ext_next      = ext_reg;
        cnt_next      = cnt_reg;
        make_next     = 1'b0;
        break_next    = 1'b0;
        err_next      = 1'b0;
        do_make       = 1'b0;
        do_break      = 1'b0;
        ev_ext        = 1'b0;

        if (accept) begin
            // A byte landing on the timeout edge wins over the timeout.
            to_cnt_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_data == PS2_PFX_EXT)      state_next = ST_EXT;
                    else if (in_data == PS2_PFX_BRK) state_next = ST_BRK;
                    else                             do_make    = 1'b1;
                end
                ST_EXT: begin
                    if (in_data == PS2_PFX_BRK)      state_next = ST_EXT_BRK;
                    else if (in_data == PS2_PFX_EXT) err_next   = 1'b1;
                    else begin
                        do_make    = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    if (in_data == PS2_PFX_EXT || in_data == PS2_PFX_BRK) begin
                        err_next = 1'b1;
                    end else begin
                        do_break = 1'b1;
                        ev_ext   = (state_reg == ST_EXT_BRK);
                    end
                end
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (to_cnt_reg == TO_LAST) begin
                state_next  = ST_IDLE;
                err_next    = 1'b1;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end

        held_match = key_down_reg && (in_data == code_reg) && (ev_ext == ext_reg);
`ifdef PS2_TYPEMATIC_FILTER_EN
        count_make = !held_match;
`else
        count_make = 1'b1;
`endif

        if (do_make) begin
            code_next     = in_data;
            ext_next      = ev_ext;
            key_down_next = 1'b1;
            if (count_make) begin
                cnt_next  = cnt_reg + 1'b1;
                make_next = 1'b1;
            end
        end

        // Releases of anything but the held key are dropped without a trace.
        if (do_break && held_match) begin
            key_down_next = 1'b0;
            break_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            to_cnt_reg   <= '0;
            in_ready_reg <= 1'b0;
            key_down_reg <= 1'b0;
            code_reg     <= 8'h00;
            ext_reg      <= 1'b0;
            cnt_reg      <= '0;
            make_reg     <= 1'b0;
            break_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            to_cnt_reg   <= to_cnt_next;
            in_ready_reg <= 1'b1;
            key_down_reg <= key_down_next;
            code_reg     <= code_next;
            ext_reg      <= ext_next;
            cnt_reg      <= cnt_next;
            make_reg     <= make_next;
            break_reg    <= break_next;
            err_reg      <= err_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign key_down    = key_down_reg;
    assign cur_code    = code_reg;
    assign cur_ext     = ext_reg;
    assign press_cnt   = cnt_reg;
    assign make_pulse  = make_reg;
    assign break_pulse = break_reg;
    assign proto_err   = err_reg;

    // Digit order: 0 = code lo, 1 = code hi, 2 = count lo, 3 = count hi.
    logic [7:0]      cnt_disp;
    logic [3:0][3:0] nib;
    logic [3:0][7:0] seg_raw;

    assign cnt_disp = 8'(cnt_reg);
    assign nib      = {cnt_disp[7:4], cnt_disp[3:0], code_reg[7:4], code_reg[3:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            hex7seg u_hex7seg (
                .nibble (nib[gi]),
                .seg    (seg_raw[gi])
            );
        end
    endgenerate

    assign seg_code_lo = key_down_reg ? seg_raw[0] : SEG_BLANK;
    assign seg_code_hi = key_down_reg ? seg_raw[1] : SEG_BLANK;
    assign seg_cnt_lo  = seg_raw[2];
    assign seg_cnt_hi  = seg_raw[3];

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sequencing controller behind the PS/2 receiver. It pops raw scan-code bytes over a ready/valid interface, runs the set-2 prefix state machine (E0 extended, F0 break), and tracks the currently held key and a key-press counter. It drives four 7-segment digits: held code and press count. It sits between u_ps2 (or its byte FIFO) and the board seg outputs in top.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between a prefix byte and its follow-up byte before the sequence is abandoned
CNT_W, 8, width of the press counter

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  scan-code byte available from receiver/FIFO
in_data  in  8  scan-code byte
in_ready  out  1  controller accepts byte; pop when in_valid && in_ready
key_down  out  1  a key is currently held
cur_code  out  8  code of last made key (prefix stripped)
cur_ext  out  1  last made key was E0-extended
press_cnt  out  CNT_W  count of make events, wraps
make_pulse  out  1  one-cycle pulse per counted make event
break_pulse  out  1  one-cycle pulse when held key released
proto_err  out  1  one-cycle pulse on protocol error or timeout
seg_code_lo  out  8  active-low segments, cur_code[3:0]
seg_code_hi  out  8  active-low segments, cur_code[7:4]
seg_cnt_lo  out  8  active-low segments, press_cnt[3:0]
seg_cnt_hi  out  8  active-low segments, press_cnt[7:4]

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=0, key_down=0, cur_code=8'h00, cur_ext=0, press_cnt=0, all pulses 0, timeout counter 0. in_ready goes 1 on the first clk edge after rst deasserts. It stays 1 in all states afterwards, so at most one byte is accepted per cycle.
- All register outputs update on the edge that accepts the byte; they are visible the following cycle. Pulses are high for exactly that one cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - Any other byte is a make with ext=0; stay IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT and raises proto_err.
  - Any other byte is a make with ext=1; go to IDLE.
- BRK / EXT_BRK:
  - E0 or F0 raises proto_err and goes to IDLE, with no event.
  - Any other byte is a break with ext=0 (BRK) or ext=1 (EXT_BRK); go to IDLE.
- Make handling: cur_code=byte, cur_ext=ext, key_down=1.
  - press_cnt+1 modulo 2^CNT_W (FF wraps to 00 for CNT_W=8).
  - make_pulse=1.
- Break handling: if key_down && byte==cur_code && ext==cur_ext, then key_down=0 and break_pulse=1. Otherwise it is ignored silently and held state is unchanged.
- Timeout: the counter runs only in non-IDLE states and clears on every accepted byte. If it reaches TIMEOUT_CYCLES-1 with no byte, the FSM goes to IDLE, proto_err pulses, and no event is generated. A byte accepted on that same edge wins: it is processed normally and there is no timeout.
- in_valid while rst=0: ignored, not popped.
- Seg encoding: active-low, bit7=DP held 1, hex 0-F.
  - seg_code_* show 8'hFF (blank) while key_down=0.
  - seg_cnt_* are always shown.
  - Combinational from registered state.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined: a make whose code/ext equals the held key while key_down=1 is an auto-repeat. It is still consumed, but press_cnt is unchanged and there is no make_pulse.
- Undefined: every make increments press_cnt and pulses make_pulse.

Decomposition:
- Package ps2_ctrl_pkg:
  - state enum typedef (IDLE, EXT, BRK, EXT_BRK)
  - localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0
  - SEG_BLANK=8'hFF
- Sub-module hex7seg (4-bit in, 8-bit active-low out), instantiated four times.

Test Plan:
- Reset then bytes 1C, F0, 1C -> one cycle after 1C: key_down=1, cur_code=1C, cur_ext=0, press_cnt=1, make_pulse once. After 2nd 1C: key_down=0, break_pulse once. seg_code_* = FF. seg_cnt_lo = digit 1.
- E0 75, E0 F0 75 -> cur_code=75, cur_ext=1, press_cnt=1. Release clears key_down. A plain F0 75 in place of E0 F0 75 is ignored (key stays down).
- 1C 1C 1C (held repeats) -> filter defined: press_cnt=1, one make_pulse. Filter undefined: press_cnt=3, three pulses.
- E0 then no byte, TIMEOUT_CYCLES=16 -> proto_err pulse 16 cycles after E0 accept, state IDLE. A following 1C is a plain make with cur_ext=0.
- F0 F0 -> proto_err on 2nd byte, no break. 256 distinct makes -> press_cnt wraps FF to 00.
- rst asserted mid-sequence after E0 F0 -> all outputs at reset values immediately, in_ready=0. After release, 75 is a plain make with ext=0.
